// File: rtl/posit_fma_pkg.sv
// Shared constants for the FMA align/merge stage: lane widths, lane bit-slices
// for both layouts, and the run-framing FSM encoding.
package posit_fma_pkg;
    localparam int LW  = 28;
    localparam int EW  = 10;
    localparam int FLW = 2 * LW;
    localparam int FEW = 2 * EW;

    // Sign bit positions: dual lane0/lane1, and the single full lane.
    localparam int L0_S = 0;
    localparam int L1_S = 2;
    localparam int F_S  = 3;

    localparam int L0_EXP_LO  = 0;
    localparam int L1_EXP_LO  = EW;
    localparam int L0_MANT_LO = 0;
    localparam int L1_MANT_LO = LW;
    localparam int L0_SUM_LO  = 0;
    localparam int L1_SUM_LO  = LW + 1;
    localparam int SUM_W      = 2 * LW + 2;

    localparam logic [1:0] DRAIN_CYCLES = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;
endpackage

// File: rtl/align_lane.sv
// One lane of exponent-align plus signed magnitude add: stage 1 registers the
// compare/swap/shift/sticky, stage 2 registers the add/sub result.
module align_lane #(
    parameter int W   = 28,
    parameter int EWD = 10
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load1,
    input  logic           load2,
    input  logic           s_e,
    input  logic           s_f,
    input  logic [EWD-1:0] exp_e,
    input  logic [EWD-1:0] exp_f,
    input  logic [W-1:0]   mant_e,
    input  logic [W-1:0]   mant_f,
    output logic           sum_s,
    output logic [EWD-1:0] sum_exp,
    output logic [W:0]     sum_mant,
    output logic           sum_sticky
);
    logic           e_big;
    logic [EWD-1:0] exp_big, exp_small, d;
    logic [W-1:0]   m_big, m_small, m_shift;
    logic           s_big_c, s_small_c, sticky_c;

    // Ties go to E so equal exponents never swap.
    assign e_big = (exp_e >= exp_f);

    always_comb begin
        exp_big   = e_big ? exp_e  : exp_f;
        exp_small = e_big ? exp_f  : exp_e;
        m_big     = e_big ? mant_e : mant_f;
        m_small   = e_big ? mant_f : mant_e;
        s_big_c   = e_big ? s_e    : s_f;
        s_small_c = e_big ? s_f    : s_e;
        d         = exp_big - exp_small;
        if (d >= EWD'(W)) begin
            m_shift  = '0;
            sticky_c = |m_small;
        end else begin
            m_shift  = m_small >> d;
            sticky_c = |(m_small & ~({W{1'b1}} << d));
        end
    end

    logic [W-1:0]   r1_big, r1_shift;
    logic           r1_s_big, r1_s_small, r1_sticky;
    logic [EWD-1:0] r1_exp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_big     <= '0;
            r1_shift   <= '0;
            r1_s_big   <= 1'b0;
            r1_s_small <= 1'b0;
            r1_sticky  <= 1'b0;
            r1_exp     <= '0;
        end else if (load1) begin
            r1_big     <= m_big;
            r1_shift   <= m_shift;
            r1_s_big   <= s_big_c;
            r1_s_small <= s_small_c;
            r1_sticky  <= sticky_c;
            r1_exp     <= exp_big;
        end
    end

    logic [W:0] a, b, sum_c;
    logic       sign_c;

    always_comb begin
        a = {1'b0, r1_big};
        b = {1'b0, r1_shift};
        if (r1_s_big == r1_s_small) begin
            sum_c  = a + b;
            sign_c = r1_s_big;
        end else if (a >= b) begin
            sum_c  = a - b;
            sign_c = r1_s_big;
        end else begin
            sum_c  = b - a;
            sign_c = r1_s_small;
        end
        // A zero magnitude is always reported as +0.
        if (sum_c == '0) sign_c = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_s      <= 1'b0;
            sum_exp    <= '0;
            sum_mant   <= '0;
            sum_sticky <= 1'b0;
        end else if (load2) begin
            sum_s      <= sign_c;
            sum_exp    <= r1_exp;
            sum_mant   <= sum_c;
            sum_sticky <= r1_sticky;
        end
    end
endmodule

// File: rtl/align_merge.sv
// Align/merge stage: three align_lane instances (two half lanes, one full lane)
// muxed by the mode that travelled with each operation, framed by a run FSM.
module align_merge
    import posit_fma_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic             align_ctl,
    input  logic [3:0]       s_E,
    input  logic [3:0]       s_F,
    input  logic [FEW-1:0]   exp_E,
    input  logic [FEW-1:0]   exp_F,
    input  logic [FLW-1:0]   mant_E,
    input  logic [FLW-1:0]   mant_F,
    output logic [1:0]       sum_s,
    output logic [FEW-1:0]   sum_exp,
    output logic [SUM_W-1:0] sum_mant,
    output logic [1:0]       sum_sticky,
    output logic             sum_mode,
    output logic             sum_valid,
    output logic             busy,
    output logic             done
);
    state_t     state;
    logic [1:0] drain_cnt;
    logic       accept;
    logic       s1_valid, s2_valid, s1_mode, s2_mode;
    logic       unused_sbits;

    assign unused_sbits = s_E[1] ^ s_F[1];
    // start always wins over a same-cycle operand.
    assign accept = align_ctl && !start && (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                state     <= ST_ARMED;
                drain_cnt <= '0;
                busy      <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: ;
                    ST_ARMED: if (align_ctl) state <= ST_RUN;
                    ST_RUN: if (!align_ctl) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= DRAIN_CYCLES;
                    end
                    ST_DRAIN: begin
                        if (align_ctl) begin
                            state <= ST_RUN;
                        end else if (drain_cnt != 2'd0) begin
                            drain_cnt <= drain_cnt - 2'd1;
                            done      <= (drain_cnt == 2'd1);
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_mode  <= 1'b0;
            s2_mode  <= 1'b0;
        end else begin
            s1_valid <= accept;
            s2_valid <= s1_valid && !start;
            if (accept) s1_mode <= mode;
            if (s1_valid) s2_mode <= s1_mode;
        end
    end

    logic            l0_s, l1_s, lf_s, l0_st, l1_st, lf_st;
    logic [EW-1:0]   l0_exp, l1_exp;
    logic [FEW-1:0]  lf_exp;
    logic [LW:0]     l0_mant, l1_mant;
    logic [FLW:0]    lf_mant;

    align_lane #(.W(LW), .EWD(EW)) u_lane0 (
        .clk(clk), .rst(rst), .load1(accept), .load2(s1_valid),
        .s_e(s_E[L0_S]), .s_f(s_F[L0_S]),
        .exp_e(exp_E[L0_EXP_LO +: EW]), .exp_f(exp_F[L0_EXP_LO +: EW]),
        .mant_e(mant_E[L0_MANT_LO +: LW]), .mant_f(mant_F[L0_MANT_LO +: LW]),
        .sum_s(l0_s), .sum_exp(l0_exp), .sum_mant(l0_mant), .sum_sticky(l0_st)
    );

    align_lane #(.W(LW), .EWD(EW)) u_lane1 (
        .clk(clk), .rst(rst), .load1(accept), .load2(s1_valid),
        .s_e(s_E[L1_S]), .s_f(s_F[L1_S]),
        .exp_e(exp_E[L1_EXP_LO +: EW]), .exp_f(exp_F[L1_EXP_LO +: EW]),
        .mant_e(mant_E[L1_MANT_LO +: LW]), .mant_f(mant_F[L1_MANT_LO +: LW]),
        .sum_s(l1_s), .sum_exp(l1_exp), .sum_mant(l1_mant), .sum_sticky(l1_st)
    );

    align_lane #(.W(FLW), .EWD(FEW)) u_lane_full (
        .clk(clk), .rst(rst), .load1(accept), .load2(s1_valid),
        .s_e(s_E[F_S]), .s_f(s_F[F_S]),
        .exp_e(exp_E), .exp_f(exp_F),
        .mant_e(mant_E), .mant_f(mant_F),
        .sum_s(lf_s), .sum_exp(lf_exp), .sum_mant(lf_mant), .sum_sticky(lf_st)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_s      <= '0;
            sum_exp    <= '0;
            sum_mant   <= '0;
            sum_sticky <= '0;
            sum_mode   <= 1'b0;
            sum_valid  <= 1'b0;
        end else begin
            sum_valid <= s2_valid && !start;
            if (s2_valid && !start) begin
                sum_mode <= s2_mode;
                if (s2_mode) begin
                    sum_s      <= {lf_s, 1'b0};
                    sum_exp    <= lf_exp;
                    sum_mant   <= {1'b0, lf_mant};
                    sum_sticky <= {lf_st, 1'b0};
                end else begin
                    sum_s      <= {l1_s, l0_s};
                    sum_exp    <= {l1_exp, l0_exp};
                    sum_mant   <= {l1_mant, l0_mant};
                    sum_sticky <= {l1_st, l0_st};
                end
            end
        end
    end
endmodule

// File: tb/tb_align_merge.sv
// Directed bench for align_merge: hand-computed lane results, run framing,
// abort, start/align_ctl priority and asynchronous reset mid-drain.
module tb_align_merge;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic        align_ctl = 1'b0;
    logic [3:0]  s_E = '0, s_F = '0;
    logic [19:0] exp_E = '0, exp_F = '0;
    logic [55:0] mant_E = '0, mant_F = '0;
    logic [1:0]  sum_s, sum_sticky;
    logic [19:0] sum_exp;
    logic [57:0] sum_mant;
    logic        sum_mode, sum_valid, busy, done;

    int vectors = 0;
    int miscompares = 0;

    align_merge dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .align_ctl(align_ctl),
        .s_E(s_E), .s_F(s_F), .exp_E(exp_E), .exp_F(exp_F),
        .mant_E(mant_E), .mant_F(mant_F),
        .sum_s(sum_s), .sum_exp(sum_exp), .sum_mant(sum_mant), .sum_sticky(sum_sticky),
        .sum_mode(sum_mode), .sum_valid(sum_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_result(input string tag, input logic [57:0] m, input logic [19:0] e,
                              input logic [1:0] s, input logic [1:0] st, input logic md);
        chk({tag, ".valid"}, 64'(sum_valid), 64'd1);
        chk({tag, ".mant"}, 64'(sum_mant), 64'(m));
        chk({tag, ".exp"}, 64'(sum_exp), 64'(e));
        chk({tag, ".sign"}, 64'(sum_s), 64'(s));
        chk({tag, ".sticky"}, 64'(sum_sticky), 64'(st));
        chk({tag, ".mode"}, 64'(sum_mode), 64'(md));
    endtask

    // One framed run of a single operation; returns just after edge t+2.
    task automatic one_op_run(input string tag);
        start = 1'b1;
        step();
        start = 1'b0;
        align_ctl = 1'b1;
        step();
        align_ctl = 1'b0;
        step();
        chk({tag, ".early_valid"}, 64'(sum_valid), 64'd0);
        step();
    endtask

    task automatic finish_run(input string tag);
        step();
        chk({tag, ".done"}, 64'(done), 64'd1);
        chk({tag, ".busy_at_done"}, 64'(busy), 64'd1);
        step();
        chk({tag, ".done_clear"}, 64'(done), 64'd0);
        chk({tag, ".busy_clear"}, 64'(busy), 64'd0);
    endtask

    task automatic set_op1();
        mode = 1'b0;
        s_E = 4'b0100; s_F = 4'b0100;
        exp_E = {10'd20, 10'd5}; exp_F = {10'd22, 10'd3};
        mant_E = {28'h1234567, 28'h8000000}; mant_F = {28'h0800000, 28'h8000000};
    endtask

    task automatic set_op5();
        mode = 1'b1;
        s_E = 4'b1000; s_F = 4'b1000;
        exp_E = 20'h00004; exp_F = 20'h00003;
        mant_E = 56'hF0000000000000; mant_F = 56'h20000000000001;
    endtask

    initial begin
        // Reset state
        #1;
        chk("rst.sum_valid", 64'(sum_valid), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.sum_mant", 64'(sum_mant), 64'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // Dual, same sign; lane1 with F bigger and sticky bits shifted out
        set_op1();
        one_op_run("op1");
        chk_result("op1", {29'h0C8D159, 29'h0A000000}, {10'd22, 10'd5}, 2'b10, 2'b10, 1'b0);
        finish_run("op1");

        // Dual, opposite sign, equal exponents, negative difference
        mode = 1'b0;
        s_E = 4'b0000; s_F = 4'b0001;
        exp_E = {10'd0, 10'd7}; exp_F = {10'd0, 10'd7};
        mant_E = {28'h0, 28'h4000000}; mant_F = {28'h0, 28'h6000000};
        one_op_run("op2");
        chk_result("op2", {29'h0, 29'h2000000}, {10'd0, 10'd7}, 2'b01, 2'b00, 1'b0);
        finish_run("op2");

        // Dual saturation on lane0 (d = 40), independent subtract on lane1
        mode = 1'b0;
        s_E = 4'b0000; s_F = 4'b0100;
        exp_E = {10'd3, 10'd50}; exp_F = {10'd3, 10'd10};
        mant_E = {28'h0000100, 28'h9ABCDEF}; mant_F = {28'h0000300, 28'h0000001};
        one_op_run("op3");
        chk_result("op3", {29'h200, 29'h9ABCDEF}, {10'd3, 10'd50}, 2'b10, 2'b01, 1'b0);
        finish_run("op3");

        // Single-lane exact cancellation
        mode = 1'b1;
        s_E = 4'b0000; s_F = 4'b1000;
        exp_E = 20'h00100; exp_F = 20'h00100;
        mant_E = 56'hFFFFFFFFFFFFFF; mant_F = 56'hFFFFFFFFFFFFFF;
        one_op_run("op4");
        chk_result("op4", 58'h0, 20'h00100, 2'b00, 2'b00, 1'b1);
        finish_run("op4");

        // Single-lane with carry out and sticky
        set_op5();
        one_op_run("op5");
        chk_result("op5", 58'h100000000000000, 20'h00004, 2'b10, 2'b10, 1'b1);
        finish_run("op5");

        // Run framing: two back-to-back operations of different modes
        start = 1'b1;
        step();
        start = 1'b0;
        chk("frame.busy_armed", 64'(busy), 64'd1);
        set_op1();
        align_ctl = 1'b1;
        step();
        set_op5();
        step();
        align_ctl = 1'b0;
        chk("frame.t1_valid", 64'(sum_valid), 64'd0);
        step();
        chk_result("frame.a", {29'h0C8D159, 29'h0A000000}, {10'd22, 10'd5}, 2'b10, 2'b10, 1'b0);
        step();
        chk_result("frame.b", 58'h100000000000000, 20'h00004, 2'b10, 2'b10, 1'b1);
        chk("frame.no_early_done", 64'(done), 64'd0);
        step();
        chk("frame.t4_valid", 64'(sum_valid), 64'd0);
        chk("frame.done", 64'(done), 64'd1);
        chk("frame.busy_t4", 64'(busy), 64'd1);
        step();
        chk("frame.done_clear", 64'(done), 64'd0);
        chk("frame.busy_t5", 64'(busy), 64'd0);

        // IDLE ignores align_ctl; outputs hold
        set_op1();
        align_ctl = 1'b1;
        step();
        align_ctl = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle.no_valid", 64'(sum_valid), 64'd0);
        end
        chk("idle.hold_mant", 64'(sum_mant), 64'h100000000000000);
        chk("idle.hold_mode", 64'(sum_mode), 64'd1);

        // Abort: start again while one result is in flight
        start = 1'b1;
        step();
        start = 1'b0;
        align_ctl = 1'b1;
        step();
        align_ctl = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("abort.no_valid", 64'(sum_valid), 64'd0);
            chk("abort.no_done", 64'(done), 64'd0);
        end
        chk("abort.busy", 64'(busy), 64'd1);

        // start together with align_ctl: operand is dropped
        start = 1'b1;
        align_ctl = 1'b1;
        step();
        start = 1'b0;
        align_ctl = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("startwins.no_valid", 64'(sum_valid), 64'd0);
        end

        // Reset in the middle of DRAIN
        mode = 1'b0;
        s_E = 4'b0000; s_F = 4'b0001;
        exp_E = {10'd0, 10'd7}; exp_F = {10'd0, 10'd7};
        mant_E = {28'h0, 28'h4000000}; mant_F = {28'h0, 28'h6000000};
        align_ctl = 1'b1;
        step();
        align_ctl = 1'b0;
        step();
        step();
        chk("drain.valid_before_rst", 64'(sum_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid.sum_valid", 64'(sum_valid), 64'd0);
        chk("rst_mid.busy", 64'(busy), 64'd0);
        chk("rst_mid.done", 64'(done), 64'd0);
        chk("rst_mid.sum_mant", 64'(sum_mant), 64'd0);
        chk("rst_mid.sum_exp", 64'(sum_exp), 64'd0);
        chk("rst_mid.sum_s", 64'(sum_s), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst.no_valid", 64'(sum_valid), 64'd0);
            chk("post_rst.no_done", 64'(done), 64'd0);
            chk("post_rst.busy", 64'(busy), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/align_merge.md
Name: align_merge

Overview:
- Stage directly downstream of the FMA lane-routing control stage.
- Consumes the routed E/F operand pairs (sign, exponent, mantissa) while align_ctl is high.
- Per lane: aligns the smaller-exponent mantissa to the larger one, with sticky, then adds or subtracts by sign.
- Two-stage pipeline; issues one aligned sum per accepted cycle to the normalise/round stage. A small FSM frames each run and pulses done.

Parameters:
- LW, 28, half-lane mantissa width (full lane = 2*LW = 56).
- EW, 10, half-lane exponent width (full lane = 2*EW = 20).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin new run; same cycle as the control stage's start.
- mode  in  1  lane layout: 0 = dual half lanes, 1 = single full lane.
- align_ctl  in  1  operand valid; one operation per high cycle.
- s_E, s_F  in  4 each  signs. Dual: lane0 = bit0, lane1 = bit2. Single: bit3.
- exp_E, exp_F  in  20 each  unsigned exponents. Dual: lane0 = [9:0], lane1 = [19:10]. Single: [19:0].
- mant_E, mant_F  in  56 each  mantissas. Dual: lane0 = [27:0], lane1 = [55:28]. Single: [55:0].
- sum_s  out  2  result signs. Dual: bit0 = lane0, bit1 = lane1. Single: bit1, with bit0 = 0.
- sum_exp  out  20  result exponent, same lane layout as exp_E.
- sum_mant  out  58  result magnitude incl. carry. Dual: lane0 = [28:0], lane1 = [57:29]. Single: [56:0], with [57] = 0.
- sum_sticky  out  2  OR of shifted-out bits. Dual: one bit per lane. Single: bit1.
- sum_mode  out  1  mode that travelled with this result.
- sum_valid  out  1  result valid, single-cycle per operation.
- busy  out  1  high from start until done.
- done  out  1  one-cycle pulse at end of run.

Behaviour:
- Reset (async, rst = 1):
  - All outputs 0, both pipeline valid bits 0, FSM = IDLE.
  - Reset mid-run discards in-flight results; no sum_valid or done follows.
- Lane op, with W = LW (dual) or 2*LW (single):
  - big = E if exp_E >= exp_F, else F; small = the other. On a tie, big = E.
  - d = exp_big - exp_small. Shift small right by min(d, W).
  - sticky = OR of all bits shifted out. If d >= W, the shifted value is 0 and sticky = OR of the whole small mantissa.
  - Signs equal: sum = big + shifted small (W+1 bits), sign = s_big.
  - Signs differ: r = big - shifted small. If r < 0, sum = -r and sign = s_small; else sum = r and sign = s_big.
  - Zero magnitude: sign forced to 0, sticky still reported.
  - Result exponent = exp_big.
  - Dual-mode lanes are fully independent; no carry or shift crosses the lane boundary.
- Pipeline:
  - Stage 1 registers compare/swap/shift plus mode. Stage 2 registers add/sub.
  - Input accepted at edge t (align_ctl = 1 and FSM in ARMED or RUN): result registered with sum_valid = 1 after edge t+2.
  - Throughput one per cycle; no back-pressure.
  - mode is sampled with each operation. Back-to-back operations of different modes are legal.
  - sum_* hold their last value when sum_valid = 0.
- FSM, states IDLE, ARMED, RUN, DRAIN:
  - IDLE: start -> ARMED. align_ctl is ignored (not accepted).
  - ARMED: busy = 1. align_ctl -> RUN.
  - RUN: accepts while align_ctl = 1. align_ctl = 0 -> DRAIN, drain counter = 2.
  - DRAIN: counter decrements. At 0, done pulses for one cycle (coincident with the cycle after the last sum_valid) -> IDLE, busy = 0.
  - start in any non-IDLE state: both pipeline valid bits cleared, drain counter cleared, -> ARMED, no done pulse for the aborted run.
  - start together with align_ctl: start wins; that cycle's operand is not accepted.
  - align_ctl reasserting in DRAIN: accepted, -> RUN.
  - ARMED with no align_ctl: waits indefinitely.

Decomposition:
- Shared package posit_fma_pkg: LW, EW, the lane bit-slice constants for s/exp/mant/sum in both modes, and the FSM state encoding.
- One sub-module, align_lane: a single lane's compare/swap/shift/sticky/add-sub, parameterised on width. Instantiated for lane0, lane1 and the full lane; mode muxes their outputs.

Test Plan:
- Dual, lane0 same sign: exp_E = 5, mant_E = 0x8000000, exp_F = 3, mant_F = 0x8000000, signs 0 -> sum_mant[28:0] = 0x0A000000, sum_exp[9:0] = 5, sticky0 = 0, sign0 = 0, sum_valid at t+2.
- Dual, lane0 opposite sign, equal exp 7: mant_E = 0x4000000 (s = 0), mant_F = 0x6000000 (s = 1) -> sum = 0x2000000, sign0 = 1, exp 7.
- Dual saturation: exp_E = 50, exp_F = 10, mant_F = 0x1 -> lane0 sum = mant_E, sticky0 = 1. Lane1 driven with independent values; lane1 result unaffected.
- Single-lane cancellation: exp 0x00100 on both, mant 0xFFFFFFFFFFFFFF, s_E[3] = 0, s_F[3] = 1 -> sum_mant = 0, sum_s = 0, sticky 0.
- Run framing: start, then align_ctl high 2 cycles (mode 0 then 1) -> sum_valid at t+2 and t+3 with sum_mode 0 then 1, done pulse at t+4, busy low from t+5.
- Abort/reset: start reasserted while one result is in flight -> no sum_valid, no done. Separately, rst mid-DRAIN -> all outputs 0 immediately, IDLE.
